// File: rtl/ibf_diff_scanner.sv
// ibf_diff_scanner
// Streams two programmed IBFs cell by cell, stores their difference IBF
// (key XOR, sig XOR, count A-B) in an internal RAM, then scans it for pure
// cells. Every +1/-1 cell has its key checked against the external signature
// unit. Verified pure cells are handed to the peeling decoder, tagged with the
// side they came from (0: A only, 1: B only).
//
// Handshakes: a transfer on a valid/ready pair happens on the rising clk edge
// where both are 1. A producer never drops valid and never changes its payload
// while valid is high and ready is low. This holds for in_valid/in_ready
// (the bench is the producer) and for pure_valid/pure_ready (the block is the
// producer). chk_req/chk_done are single-cycle pulses rather than a handshake.
// chk_key is held from chk_req until chk_done.
module ibf_diff_scanner #(
   parameter int KEY_W    = 32,
   parameter int SIG_W    = 8,
   parameter int CNT_W    = 8,
   parameter int IBF_SIZE = 64,
   parameter int IDX_W    = 6
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          Start,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [KEY_W+SIG_W+CNT_W-1:0]  cell_a,
   input  logic [KEY_W+SIG_W+CNT_W-1:0]  cell_b,
   output logic                          chk_req,
   output logic [KEY_W-1:0]              chk_key,
   input  logic                          chk_done,
   input  logic [SIG_W-1:0]              chk_sig,
   output logic                          pure_valid,
   input  logic                          pure_ready,
   output logic [KEY_W-1:0]              pure_key,
   output logic [IDX_W-1:0]              pure_index,
   output logic                          pure_side,
   output logic [IDX_W:0]                nonzero_cnt,
   output logic [IDX_W:0]                pure_cnt,
   output logic                          Done,
   output logic                          empty,
   output logic [2:0]                    dbg_state
);

   localparam int CELL_W = KEY_W + SIG_W + CNT_W;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(IBF_SIZE - 1);
   localparam logic [CNT_W-1:0] CNT_PLUS  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MINUS = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_SCAN_RD   = 3'd2,
      S_SCAN_EVAL = 3'd3,
      S_CHK_REQ   = 3'd4,
      S_CHK_WAIT  = 3'd5,
      S_EMIT      = 3'd6,
      S_DONE      = 3'd7
   } state_t;

   state_t state;
   state_t next_state;

   // Field views of the incoming cell pair
   logic [KEY_W-1:0] a_key, b_key;
   logic [SIG_W-1:0] a_sig, b_sig;
   logic [CNT_W-1:0] a_cnt, b_cnt;
   logic [CELL_W-1:0] diff_cell;
   logic              diff_nz;

   // Difference IBF storage and its registered read port
   logic [CELL_W-1:0] ram [IBF_SIZE];
   logic [CELL_W-1:0] rd_data;
   logic [KEY_W-1:0]  rd_key;
   logic [SIG_W-1:0]  rd_sig;
   logic [CNT_W-1:0]  rd_cnt;

   // Pass bookkeeping
   logic [IDX_W-1:0] load_idx;
   logic [IDX_W-1:0] scan_idx;

   // Control strobes from the FSM to the datapath
   logic clear_pass;
   logic load_fire;
   logic scan_advance;
   logic pure_fire;
   logic is_candidate;

   assign a_key = cell_a[CELL_W-1 -: KEY_W];
   assign b_key = cell_b[CELL_W-1 -: KEY_W];
   assign a_sig = cell_a[CNT_W +: SIG_W];
   assign b_sig = cell_b[CNT_W +: SIG_W];
   assign a_cnt = cell_a[CNT_W-1:0];
   assign b_cnt = cell_b[CNT_W-1:0];

   // Count subtraction wraps modulo 2^CNT_W, giving the two's complement difference
   assign diff_cell = {a_key ^ b_key, a_sig ^ b_sig, a_cnt - b_cnt};
   assign diff_nz   = (diff_cell != '0);

   assign rd_key = rd_data[CELL_W-1 -: KEY_W];
   assign rd_sig = rd_data[CNT_W +: SIG_W];
   assign rd_cnt = rd_data[CNT_W-1:0];

   // Only +1 / -1 cells can be pure; count 0 with leftover key/sig never is
   assign is_candidate = (rd_cnt == CNT_PLUS) || (rd_cnt == CNT_MINUS);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and control decode
   always_comb begin
      next_state   = state;
      in_ready     = 1'b0;
      chk_req      = 1'b0;
      pure_valid   = 1'b0;
      Done         = 1'b0;
      clear_pass   = 1'b0;
      load_fire    = 1'b0;
      scan_advance = 1'b0;
      pure_fire    = 1'b0;

      case (state)
         S_IDLE: begin
            if (Start) begin
               clear_pass = 1'b1;
               next_state = S_LOAD;
            end
         end
         S_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load_fire = 1'b1;
               if (load_idx == LAST_IDX) begin
                  next_state = S_SCAN_RD;
               end
            end
         end
         S_SCAN_RD: begin
            next_state = S_SCAN_EVAL;
         end
         S_SCAN_EVAL: begin
            if (is_candidate) begin
               next_state = S_CHK_REQ;
            end else begin
               scan_advance = 1'b1;
            end
         end
         S_CHK_REQ: begin
            chk_req    = 1'b1;
            next_state = S_CHK_WAIT;
         end
         S_CHK_WAIT: begin
            if (chk_done) begin
               if (chk_sig == rd_sig) begin
                  next_state = S_EMIT;
               end else begin
                  scan_advance = 1'b1;
               end
            end
         end
         S_EMIT: begin
            pure_valid = 1'b1;
            if (pure_ready) begin
               pure_fire    = 1'b1;
               scan_advance = 1'b1;
            end
         end
         S_DONE: begin
            Done = 1'b1;
            if (Start) begin
               clear_pass = 1'b1;
               next_state = S_LOAD;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase

      // Moving past a cell either scans the next one or ends the pass
      if (scan_advance) begin
         next_state = (scan_idx == LAST_IDX) ? S_DONE : S_SCAN_RD;
      end
   end

   // Load/scan indices and the two pass counters
   always_ff @(posedge clk) begin
      if (reset) begin
         load_idx    <= '0;
         scan_idx    <= '0;
         nonzero_cnt <= '0;
         pure_cnt    <= '0;
      end else begin
         if (clear_pass) begin
            load_idx    <= '0;
            scan_idx    <= '0;
            nonzero_cnt <= '0;
            pure_cnt    <= '0;
         end
         if (load_fire) begin
            load_idx    <= load_idx + IDX_W'(1);
            nonzero_cnt <= nonzero_cnt + (IDX_W+1)'(diff_nz);
         end
         // scan_idx parks on the last cell so pure_index stays meaningful in DONE
         if (scan_advance && (scan_idx != LAST_IDX)) begin
            scan_idx <= scan_idx + IDX_W'(1);
         end
         if (pure_fire) begin
            pure_cnt <= pure_cnt + (IDX_W+1)'(1);
         end
      end
   end

   // Difference RAM write port; contents are fully rewritten every load
   always_ff @(posedge clk) begin
      if (load_fire) begin
         ram[load_idx] <= diff_cell;
      end
   end

   // Synchronous read; the word is held through check and emit for this cell
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= '0;
      end else if (state == S_SCAN_RD) begin
         rd_data <= ram[scan_idx];
      end
   end

   assign chk_key    = rd_key;
   assign pure_key   = rd_key;
   assign pure_index = scan_idx;
   assign pure_side  = (rd_cnt == CNT_MINUS);
   assign empty      = (state == S_DONE) && (nonzero_cnt == '0);
   assign dbg_state  = state;

endmodule

// File: tb/tb_ibf_diff_scanner.sv
// tb_ibf_diff_scanner
// Self-checking bench: builds two IBFs in plain arrays, predicts the chk_req
// keys and the pure cells from the difference rules, and checks the DUT
// against those predictions while acting as the CRC unit and the consumer.
module tb_ibf_diff_scanner;

   localparam int KEY_W    = 32;
   localparam int SIG_W    = 8;
   localparam int CNT_W    = 8;
   localparam int IBF_SIZE = 64;
   localparam int IDX_W    = 6;
   localparam int CELL_W   = KEY_W + SIG_W + CNT_W;
   localparam int PW       = KEY_W + IDX_W + 1;

   // ---------------- clock / reset and DUT ----------------
   logic               clk;
   logic               reset;
   logic               Start;
   logic               in_valid;
   logic               in_ready;
   logic [CELL_W-1:0]  cell_a;
   logic [CELL_W-1:0]  cell_b;
   logic               chk_req;
   logic [KEY_W-1:0]   chk_key;
   logic               chk_done;
   logic [SIG_W-1:0]   chk_sig;
   logic               pure_valid;
   logic               pure_ready;
   logic [KEY_W-1:0]   pure_key;
   logic [IDX_W-1:0]   pure_index;
   logic               pure_side;
   logic [IDX_W:0]     nonzero_cnt;
   logic [IDX_W:0]     pure_cnt;
   logic               Done;
   logic               empty;
   logic [2:0]         dbg_state;

   ibf_diff_scanner #(
      .KEY_W(KEY_W), .SIG_W(SIG_W), .CNT_W(CNT_W), .IBF_SIZE(IBF_SIZE), .IDX_W(IDX_W)
   ) dut (
      .clk(clk), .reset(reset), .Start(Start),
      .in_valid(in_valid), .in_ready(in_ready), .cell_a(cell_a), .cell_b(cell_b),
      .chk_req(chk_req), .chk_key(chk_key), .chk_done(chk_done), .chk_sig(chk_sig),
      .pure_valid(pure_valid), .pure_ready(pure_ready), .pure_key(pure_key),
      .pure_index(pure_index), .pure_side(pure_side),
      .nonzero_cnt(nonzero_cnt), .pure_cnt(pure_cnt), .Done(Done), .empty(empty),
      .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int n_vec  = 0;
   int n_miss = 0;
   logic [KEY_W-1:0] exp_chk_q[$];
   logic [PW-1:0]    exp_pure_q[$];
   int exp_nz;
   int exp_np;

   // IBF contents for the current pass
   logic [KEY_W-1:0] a_key [IBF_SIZE];
   logic [KEY_W-1:0] b_key [IBF_SIZE];
   logic [SIG_W-1:0] a_sig [IBF_SIZE];
   logic [SIG_W-1:0] b_sig [IBF_SIZE];
   logic [CNT_W-1:0] a_cnt [IBF_SIZE];
   logic [CNT_W-1:0] b_cnt [IBF_SIZE];

   // Responder / consumer configuration and observations
   bit               stub_fixed_en = 1'b0;
   logic [SIG_W-1:0] stub_fixed_val = '0;
   bit               stub_rand = 1'b1;
   int               stub_delay = 0;
   bit               ready_rand = 1'b0;
   int               hold_cnt = 0;
   bit               abort = 1'b0;
   int               n_chk_seen = 0;
   int               n_pure_seen = 0;
   int               stall_first = 0;
   logic [KEY_W-1:0] last_chk_key = '0;
   logic [KEY_W-1:0] last_pure_key = '0;
   logic [IDX_W-1:0] last_pure_idx = '0;
   logic             last_pure_side = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // The signature the simulated CRC unit returns for a key
   function automatic logic [SIG_W-1:0] hash_sig(input logic [KEY_W-1:0] k);
      return k[7:0] ^ k[15:8] ^ k[23:16] ^ k[31:24] ^ 8'h5A;
   endfunction

   function automatic logic [SIG_W-1:0] stub_sig(input logic [KEY_W-1:0] k);
      return stub_fixed_en ? stub_fixed_val : hash_sig(k);
   endfunction

   // ---------------- reference model ----------------
   task automatic clear_model();
      for (int i = 0; i < IBF_SIZE; i++) begin
         a_key[i] = '0; b_key[i] = '0;
         a_sig[i] = '0; b_sig[i] = '0;
         a_cnt[i] = '0; b_cnt[i] = '0;
      end
   endtask

   // Difference rules applied directly to the two IBFs, in index order
   task automatic build_expect();
      logic [KEY_W-1:0] dk;
      logic [SIG_W-1:0] ds;
      logic [CNT_W-1:0] dc;
      exp_chk_q.delete();
      exp_pure_q.delete();
      exp_nz = 0;
      exp_np = 0;
      for (int i = 0; i < IBF_SIZE; i++) begin
         dk = a_key[i] ^ b_key[i];
         ds = a_sig[i] ^ b_sig[i];
         dc = a_cnt[i] - b_cnt[i];
         if (dk != 0 || ds != 0 || dc != 0) exp_nz++;
         if (dc == 8'd1 || dc == 8'hFF) begin
            exp_chk_q.push_back(dk);
            if (ds == stub_sig(dk)) begin
               exp_pure_q.push_back({dk, IDX_W'(i), (dc == 8'hFF)});
               exp_np++;
            end
         end
      end
   endtask

   // Random IBF pair: B random, A = B plus a chosen difference per cell
   task automatic gen_random();
      logic [KEY_W-1:0] dk;
      logic [SIG_W-1:0] ds;
      logic [CNT_W-1:0] dc;
      int cat;
      for (int i = 0; i < IBF_SIZE; i++) begin
         b_key[i] = $urandom;
         b_sig[i] = SIG_W'($urandom);
         b_cnt[i] = CNT_W'($urandom);
         cat = int'($urandom_range(0, 11));
         dk = '0; ds = '0; dc = '0;
         case (cat)
            1: begin dk = $urandom; ds = hash_sig(dk); dc = 8'd1;  end
            2: begin dk = $urandom; ds = hash_sig(dk); dc = 8'hFF; end
            3: begin
               dk = $urandom;
               ds = hash_sig(dk) ^ SIG_W'($urandom_range(1, 255));
               dc = ($urandom_range(0, 1) == 0) ? 8'd1 : 8'hFF;
            end
            4: begin dk = $urandom | 32'd1; ds = SIG_W'($urandom); dc = 8'd0; end
            5: begin dk = $urandom; ds = SIG_W'($urandom); dc = CNT_W'($urandom_range(2, 254)); end
            default: ;
         endcase
         a_key[i] = b_key[i] ^ dk;
         a_sig[i] = b_sig[i] ^ ds;
         a_cnt[i] = b_cnt[i] + dc;
      end
   endtask

   // ---------------- monitor: CRC responder, consumer, compare ----------------
   int               countdown = 0;
   bit               waiting = 1'b0;
   logic [KEY_W-1:0] cap_key = '0;
   bit               prev_stall = 1'b0;
   logic [PW-1:0]    saved_pure = '0;

   initial begin
      chk_done   = 1'b0;
      chk_sig    = '0;
      pure_ready = 1'b0;
   end

   always @(negedge clk) begin
      if (abort) begin
         waiting    = 1'b0;
         prev_stall = 1'b0;
      end
      if (chk_done) begin
         chk_done = 1'b0;
         chk_sig  = SIG_W'($urandom);
      end
      if (countdown > 0) begin
         countdown--;
         if (countdown == 0) begin
            chk_done = 1'b1;
            chk_sig  = stub_sig(cap_key);
         end
      end
      if (waiting) begin
         check("chk_key_stable", 64'(chk_key), 64'(cap_key));
         if (chk_done) waiting = 1'b0;
      end
      if (chk_req) begin
         n_chk_seen++;
         last_chk_key = chk_key;
         if (exp_chk_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL chk_req_unexpected: got key 0x%0h, expected no request", chk_key);
         end else begin
            check("chk_key", 64'(chk_key), 64'(exp_chk_q.pop_front()));
         end
         cap_key   = chk_key;
         waiting   = 1'b1;
         countdown = (stub_rand ? int'($urandom_range(0, 4)) : stub_delay) + 1;
      end

      if (prev_stall) begin
         check("pure_valid_held", 64'(pure_valid), 64'(1));
         check("pure_stable", 64'({pure_key, pure_index, pure_side}), 64'(saved_pure));
      end
      if (pure_valid && hold_cnt > 0) begin
         pure_ready = 1'b0;
         hold_cnt--;
      end else begin
         pure_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (pure_valid && pure_ready) begin
         n_pure_seen++;
         last_pure_key  = pure_key;
         last_pure_idx  = pure_index;
         last_pure_side = pure_side;
         if (exp_pure_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL pure_unexpected: got key 0x%0h idx %0d, expected none", pure_key, pure_index);
         end else begin
            check("pure_cell", 64'({pure_key, pure_index, pure_side}), 64'(exp_pure_q.pop_front()));
         end
         prev_stall = 1'b0;
      end else if (pure_valid) begin
         prev_stall = 1'b1;
         saved_pure = {pure_key, pure_index, pure_side};
         if (n_pure_seen == 0) stall_first++;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   // gap_mode: 0 continuous, 1 every other cycle, 2 random gaps
   task automatic load_cells(input int gap_mode, input bit start_in_scan);
      int i = 0;
      int cyc = 0;
      bit gap;
      @(negedge clk);
      Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      while (i < IBF_SIZE && cyc < 2000) begin
         gap = (gap_mode == 1) ? cyc[0] : (gap_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
         if (gap) begin
            in_valid = 1'b0;
            cell_a   = {KEY_W'($urandom), CELL_W'(0)} >> 0;
         end else begin
            in_valid = 1'b1;
            cell_a   = {a_key[i], a_sig[i], a_cnt[i]};
            cell_b   = {b_key[i], b_sig[i], b_cnt[i]};
            if (in_ready) i++;
         end
         cyc++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("load_accepts", 64'(i), 64'(IBF_SIZE));
      check("in_ready_drop", 64'(in_ready), 64'(0));
      if (start_in_scan) begin
         Start = 1'b1;
         @(negedge clk);
         Start = 1'b0;
      end
   endtask

   task automatic wait_done(input int budget);
      int c = 0;
      while (!Done && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("done", 64'(Done), 64'(1));
   endtask

   task automatic run_pass(input int gap_mode, input bit start_in_scan);
      build_expect();
      n_chk_seen  = 0;
      n_pure_seen = 0;
      stall_first = 0;
      load_cells(gap_mode, start_in_scan);
      wait_done(8000);
      check("nonzero_cnt", 64'(nonzero_cnt), 64'(exp_nz));
      check("pure_cnt", 64'(pure_cnt), 64'(exp_np));
      check("empty", 64'(empty), 64'(exp_nz == 0));
      check("chk_left", 64'(exp_chk_q.size()), 64'(0));
      check("pure_left", 64'(exp_pure_q.size()), 64'(0));
      repeat (3) @(negedge clk);
      check("done_held", 64'(Done), 64'(1));
      check("pure_cnt_frozen", 64'(pure_cnt), 64'(exp_np));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
      check({tag, "_chk_req"}, 64'(chk_req), 64'(0));
      check({tag, "_chk_key"}, 64'(chk_key), 64'(0));
      check({tag, "_pure_valid"}, 64'(pure_valid), 64'(0));
      check({tag, "_pure_key"}, 64'(pure_key), 64'(0));
      check({tag, "_done"}, 64'(Done), 64'(0));
      check({tag, "_empty"}, 64'(empty), 64'(0));
      check({tag, "_nonzero_cnt"}, 64'(nonzero_cnt), 64'(0));
      check({tag, "_pure_cnt"}, 64'(pure_cnt), 64'(0));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int c;
      reset    = 1'b1;
      Start    = 1'b0;
      in_valid = 1'b0;
      cell_a   = '0;
      cell_b   = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      // Identical IBFs: nothing to check, set difference is empty
      stub_rand = 1'b1;
      for (int i = 0; i < IBF_SIZE; i++) begin
         a_key[i] = $urandom; a_sig[i] = SIG_W'($urandom); a_cnt[i] = CNT_W'($urandom);
         b_key[i] = a_key[i]; b_sig[i] = a_sig[i];          b_cnt[i] = a_cnt[i];
      end
      run_pass(0, 1'b0);
      check("t1_chk_reqs", 64'(n_chk_seen), 64'(0));
      check("t1_nonzero", 64'(nonzero_cnt), 64'(0));
      check("t1_empty", 64'(empty), 64'(1));

      // One A-only cell at index 5
      clear_model();
      a_key[5] = 32'hDEADBEEF; a_sig[5] = 8'h3C; a_cnt[5] = 8'd1;
      stub_fixed_en = 1'b1; stub_fixed_val = 8'h3C;
      run_pass(0, 1'b0);
      check("t2_chk_reqs", 64'(n_chk_seen), 64'(1));
      check("t2_chk_key", 64'(last_chk_key), 64'(32'hDEADBEEF));
      check("t2_pure_key", 64'(last_pure_key), 64'(32'hDEADBEEF));
      check("t2_pure_index", 64'(last_pure_idx), 64'(5));
      check("t2_pure_side", 64'(last_pure_side), 64'(0));
      check("t2_pure_cnt", 64'(pure_cnt), 64'(1));
      check("t2_empty", 64'(empty), 64'(0));

      // Count 0xFF candidate whose signature does not match
      clear_model();
      a_key[9] = 32'h0000_00A5; a_sig[9] = 8'h11; a_cnt[9] = 8'd2;
      b_cnt[9] = 8'd3;
      stub_fixed_val = 8'h12;
      run_pass(0, 1'b0);
      check("t3_chk_key", 64'(last_chk_key), 64'(32'h0000_00A5));
      check("t3_pure_seen", 64'(n_pure_seen), 64'(0));
      check("t3_nonzero", 64'(nonzero_cnt), 64'(1));
      check("t3_pure_cnt", 64'(pure_cnt), 64'(0));
      stub_fixed_en = 1'b0;

      // Two pure cells, consumer stalls the first for 10 cycles
      clear_model();
      a_key[3]  = 32'h1234_5678; a_sig[3]  = hash_sig(32'h1234_5678); a_cnt[3]  = 8'd1;
      b_key[60] = 32'hCAFE_F00D; b_sig[60] = hash_sig(32'hCAFE_F00D); b_cnt[60] = 8'd1;
      hold_cnt = 10;
      run_pass(0, 1'b0);
      check("t4_stall_cycles", 64'(stall_first >= 10), 64'(1));
      check("t4_pure_seen", 64'(n_pure_seen), 64'(2));
      check("t4_last_index", 64'(last_pure_idx), 64'(60));
      check("t4_last_side", 64'(last_pure_side), 64'(1));
      hold_cnt = 0;

      // Gapped load, slow CRC unit, Start pulsed during the scan
      gen_random();
      stub_rand = 1'b0; stub_delay = 20;
      run_pass(1, 1'b1);
      stub_rand = 1'b1;

      // Reset while a signature check is outstanding
      clear_model();
      a_key[10] = 32'h0BAD_CAFE; a_sig[10] = hash_sig(32'h0BAD_CAFE); a_cnt[10] = 8'd1;
      build_expect();
      n_chk_seen = 0;
      stub_rand = 1'b0; stub_delay = 30;
      load_cells(0, 1'b0);
      c = 0;
      while (n_chk_seen == 0 && c < 400) begin
         @(negedge clk);
         c++;
      end
      check("t6_chk_before_reset", 64'(n_chk_seen), 64'(1));
      repeat (5) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_all_zero("abort");
      exp_chk_q.delete();
      exp_pure_q.delete();
      repeat (40) @(negedge clk);
      check("t6_idle_done", 64'(Done), 64'(0));
      check("t6_idle_pure", 64'(pure_valid), 64'(0));
      check("t6_idle_in_ready", 64'(in_ready), 64'(0));
      abort = 1'b0;
      stub_rand = 1'b1;
      gen_random();
      run_pass(0, 1'b0);

      // Randomized passes with random gaps, CRC latency and back-pressure
      ready_rand = 1'b1;
      for (int p = 0; p < 6; p++) begin
         gen_random();
         run_pass(2, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
